// File: rtl/frog_motion_ctrl_if.sv
// Bundles the frog controller's game-side inputs and its position/hop outputs.
interface frog_motion_ctrl_if;
  logic       en;
  logic       refresh_tick;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic [9:0] frog_x;
  logic [9:0] frog_y;
  logic       hop_pulse;
  logic [1:0] hop_dir;
  logic [7:0] hop_count;

  modport master (
    output en, refresh_tick, up, down, left, right,
    input  frog_x, frog_y, hop_pulse, hop_dir, hop_count
  );

  modport slave (
    input  en, refresh_tick, up, down, left, right,
    output frog_x, frog_y, hop_pulse, hop_dir, hop_count
  );
endinterface

// File: rtl/frog_motion_ctrl.sv
// Frog position controller: press-to-hop with hold-to-auto-repeat, clamped to the playfield.
//   state  | meaning
//   IDLE   | waiting for a fresh button rise
//   HOLD   | direction latched, counting frames until auto-repeat starts
//   REPEAT | auto-repeating every REPEAT_FRAMES frames while held
module frog_motion_ctrl #(
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int FROG_SIZE     = 16,
  parameter int STEP          = 16,
  parameter int X_START       = 312,
  parameter int Y_START       = 464,
  parameter int HOLD_FRAMES   = 20,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  frog_motion_ctrl_if.slave  bus
);

  localparam logic [10:0] W_STEP  = 11'(STEP);
  localparam logic [10:0] W_X_LIM = 11'(X_MAX + 1 - FROG_SIZE);
  localparam logic [10:0] W_Y_LIM = 11'(Y_MAX + 1 - FROG_SIZE);
  localparam logic [7:0]  W_HOLD_TC   = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0]  W_REPEAT_TC = 8'(REPEAT_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_btn_q, w_btn, w_rise;
  logic [1:0]  r_dir_q, w_dir_nxt, w_hop_dir;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        w_do_hop;
  logic [9:0]  r_x, r_y, w_x_new, w_y_new;
  logic        r_pulse;
  logic [1:0]  r_hop_dir;
  logic [7:0]  r_count;
  logic [10:0] w_x_ext, w_y_ext, w_x_up, w_y_up;
  logic        w_moved;

  // Bit order matches the hop_dir encoding so dir_q can index w_btn directly.
  assign w_btn  = {bus.right, bus.left, bus.down, bus.up};
  assign w_rise = w_btn & ~r_btn_q;

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_q;
    w_cnt_nxt   = r_cnt;
    w_do_hop    = 1'b0;
    w_hop_dir   = r_dir_q;
    if (!bus.en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_rise) begin
            if (w_rise[0])      w_hop_dir = 2'd0;
            else if (w_rise[1]) w_hop_dir = 2'd1;
            else if (w_rise[2]) w_hop_dir = 2'd2;
            else                w_hop_dir = 2'd3;
            w_do_hop    = 1'b1;
            w_dir_nxt   = w_hop_dir;
            w_cnt_nxt   = '0;
            w_state_nxt = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!w_btn[r_dir_q]) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (bus.refresh_tick) begin
            if (r_cnt == ((r_state == HOLD) ? W_HOLD_TC : W_REPEAT_TC)) begin
              w_do_hop    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = REPEAT;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};
  assign w_x_up  = w_x_ext + W_STEP;
  assign w_y_up  = w_y_ext + W_STEP;

  always_comb begin
    w_x_new = r_x;
    w_y_new = r_y;
    unique case (w_hop_dir)
      2'd0: w_y_new = (w_y_ext < W_STEP) ? '0 : 10'(w_y_ext - W_STEP);
      2'd1: w_y_new = (w_y_up > W_Y_LIM) ? 10'(W_Y_LIM) : 10'(w_y_up);
      2'd2: w_x_new = (w_x_ext < W_STEP) ? '0 : 10'(w_x_ext - W_STEP);
      2'd3: w_x_new = (w_x_up > W_X_LIM) ? 10'(W_X_LIM) : 10'(w_x_up);
      default: ;
    endcase
  end

  // A clamped hop leaves the position unchanged and is not reported.
  assign w_moved = (w_x_new != r_x) || (w_y_new != r_y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_btn_q   <= '0;
      r_dir_q   <= '0;
      r_cnt     <= '0;
      r_x       <= 10'(X_START);
      r_y       <= 10'(Y_START);
      r_pulse   <= 1'b0;
      r_hop_dir <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_btn_q <= w_btn;
      r_dir_q <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_do_hop && w_moved;
      if (w_do_hop && w_moved) begin
        r_x       <= w_x_new;
        r_y       <= w_y_new;
        r_hop_dir <= w_hop_dir;
        if (r_count != 8'hFF) r_count <= r_count + 8'd1;
      end
    end
  end

  assign bus.frog_x    = r_x;
  assign bus.frog_y    = r_y;
  assign bus.hop_pulse = r_pulse;
  assign bus.hop_dir   = r_hop_dir;
  assign bus.hop_count = r_count;

endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Directed bench for frog_motion_ctrl: vector table plus hold/repeat, clamp, saturation and reset sequences.
module tb_frog_motion_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses;

  frog_motion_ctrl_if bus();

  frog_motion_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic en, up, down, left, right;
    int   x, y, p, d, c;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int x, input int y, input int p, input int d, input int c);
    chk({tag, ".x"}, int'(bus.frog_x), x);
    chk({tag, ".y"}, int'(bus.frog_y), y);
    chk({tag, ".pulse"}, int'(bus.hop_pulse), p);
    chk({tag, ".dir"}, int'(bus.hop_dir), d);
    chk({tag, ".count"}, int'(bus.hop_count), c);
  endtask

  task automatic set_in(input logic en, input logic u, input logic d, input logic l, input logic r, input logic t);
    bus.en = en; bus.up = u; bus.down = d; bus.left = l; bus.right = r; bus.refresh_tick = t;
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.hop_pulse) pulses++;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    pulses = 0;
  endtask

  task automatic tap_left();
    bus.left = 1'b1; step(); bus.left = 1'b0; step(); step();
  endtask

  task automatic tap_right();
    bus.right = 1'b1; step(); bus.right = 1'b0; step(); step();
  endtask

  initial begin
    int tick_at[$];
    //          en up dn lf rt   x    y  p  d  c
    tbl[0]  = '{1, 1, 0, 0, 0, 312, 448, 1, 0, 1};
    tbl[1]  = '{1, 1, 0, 0, 0, 312, 448, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 0, 0, 312, 448, 0, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 0, 312, 448, 0, 0, 1};
    tbl[4]  = '{1, 1, 0, 1, 0, 312, 432, 1, 0, 2};
    tbl[5]  = '{1, 1, 0, 0, 0, 312, 432, 0, 0, 2};
    tbl[6]  = '{1, 1, 0, 1, 0, 312, 432, 0, 0, 2};
    tbl[7]  = '{1, 0, 0, 0, 0, 312, 432, 0, 0, 2};
    tbl[8]  = '{0, 1, 0, 0, 0, 312, 432, 0, 0, 2};
    tbl[9]  = '{0, 1, 0, 0, 0, 312, 432, 0, 0, 2};
    tbl[10] = '{1, 1, 0, 0, 0, 312, 432, 0, 0, 2};
    tbl[11] = '{1, 0, 0, 0, 0, 312, 432, 0, 0, 2};
    tbl[12] = '{1, 1, 0, 0, 0, 312, 416, 1, 0, 3};
    tbl[13] = '{1, 0, 0, 0, 0, 312, 416, 0, 0, 3};
    tbl[14] = '{1, 0, 0, 0, 1, 328, 416, 1, 3, 4};
    tbl[15] = '{1, 0, 0, 0, 0, 328, 416, 0, 3, 4};
    tbl[16] = '{1, 0, 1, 0, 0, 328, 432, 1, 1, 5};
    tbl[17] = '{1, 0, 0, 0, 0, 328, 432, 0, 1, 5};
    tbl[18] = '{1, 0, 0, 1, 0, 312, 432, 1, 2, 6};
    tbl[19] = '{1, 0, 0, 0, 0, 312, 432, 0, 2, 6};
    tbl[20] = '{0, 0, 0, 1, 0, 312, 432, 0, 2, 6};

    do_reset();
    chk_all("reset", 312, 464, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].en, tbl[i].up, tbl[i].down, tbl[i].left, tbl[i].right, 1'b0);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].p, tbl[i].d, tbl[i].c);
    end

    // Hold right through 40 frames: hops at the press and on ticks 20, 28 and 36.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    if (bus.hop_pulse) tick_at.push_back(0);
    for (int t = 1; t <= 40; t++) begin
      for (int k = 0; k < 99; k++) begin
        step();
        if (bus.hop_pulse) tick_at.push_back(-t);
      end
      bus.refresh_tick = 1'b1;
      step();
      bus.refresh_tick = 1'b0;
      if (bus.hop_pulse) tick_at.push_back(t);
    end
    chk("repeat.hops", tick_at.size(), 4);
    if (tick_at.size() == 4) begin
      chk("repeat.t0", tick_at[0], 0);
      chk("repeat.t1", tick_at[1], 20);
      chk("repeat.t2", tick_at[2], 28);
      chk("repeat.t3", tick_at[3], 36);
    end
    chk_all("repeat.end", 376, 464, 0, 3, 4);
    bus.right = 1'b0;
    step();

    // Down from the bottom row is blocked; left taps clamp at column 0.
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("down.blocked", 312, 464, 0, 0, 0);
    bus.down = 1'b0;
    step();
    step();
    pulses = 0;
    for (int i = 0; i < 30; i++) tap_left();
    chk("left.pulses", pulses, 20);
    chk_all("left.clamp", 0, 464, 0, 2, 20);

    pulses = 0;
    for (int i = 0; i < 45; i++) tap_right();
    chk("right.pulses", pulses, 39);
    chk_all("right.clamp", 624, 464, 0, 3, 59);
    for (int i = 0; i < 100; i++) begin
      tap_left();
      tap_right();
    end
    chk_all("count.sat", 624, 464, 0, 3, 255);

    // Reset asserted while auto-repeating, then released with up still held.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("rst.press", 312, 448, 1, 0, 1);
    for (int t = 0; t < 23; t++) begin
      bus.refresh_tick = 1'b1; step();
      bus.refresh_tick = 1'b0; step(); step();
    end
    chk_all("rst.in_repeat", 312, 432, 0, 0, 2);
    #1;
    reset = 1'b0;
    #1;
    chk_all("rst.async", 312, 464, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk_all("rst.rehop", 312, 448, 1, 0, 1);
    step();
    chk("rst.single_pulse", int'(bus.hop_pulse), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
